// File: rtl/shared_timer_ctrl.sv
// Round-robin sharing of one up-counting interval timer between two requesters.
// The winner's length is captured at grant; done pulses once the count reaches it.
//
// state | meaning
// IDLE  | no job; arbitrate among pending requests
// RUN   | counting for the granted requester
// DONE  | one dead cycle after completion, done pulse visible
module shared_timer_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic             last;
    logic             pick;
    logic             cur;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

    assign cur = gnt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= 2'b00;
            busy   <= 1'b0;
            done   <= 2'b00;
            count  <= '0;
            target <= '0;
            last   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 2'b00;
                    if (req != 2'b00) begin
                        gnt    <= pick ? 2'b10 : 2'b01;
                        target <= pick ? len1 : len0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (!req[cur]) begin
                        gnt   <= 2'b00;
                        busy  <= 1'b0;
                        last  <= cur;
                        state <= IDLE;
                    end else if (count == target) begin
                        gnt   <= 2'b00;
                        busy  <= 1'b0;
                        done  <= cur ? 2'b10 : 2'b01;
                        last  <= cur;
                        state <= DONE;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
                DONE: begin
                    done  <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    done  <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_timer_ctrl.sv
// Directed bench for shared_timer_ctrl: reset, contention, alternation, abort,
// length bounds, reset mid-run and a single job, with hand-computed expectations.
module tb_shared_timer_ctrl;

    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic [1:0]       gnt;
    logic             busy;
    logic [1:0]       done;
    logic [WIDTH-1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    shared_timer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] e_gnt, input logic e_busy,
                           input logic [1:0] e_done, input logic [WIDTH-1:0] e_count);
        chk({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        chk({tag, ".busy"},  32'(busy),  32'(e_busy));
        chk({tag, ".done"},  32'(done),  32'(e_done));
        chk({tag, ".count"}, 32'(count), 32'(e_count));
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b11;
        len0  = 3'd1;
        len1  = 3'd2;

        // reset held two cycles with both requesting
        tick(); chk_out("rst1", 2'b00, 1'b0, 2'b00, 3'd0);
        tick(); chk_out("rst2", 2'b00, 1'b0, 2'b00, 3'd0);

        // contention: len0=1, len1=2; requester 0 first
        reset = 1'b0;
        tick(); chk_out("ct_e1", 2'b01, 1'b1, 2'b00, 3'd0);
        tick(); chk_out("ct_e2", 2'b01, 1'b1, 2'b00, 3'd1);
        tick(); chk_out("ct_e3", 2'b00, 1'b0, 2'b01, 3'd1);
        req = 2'b10;
        tick(); chk_out("ct_e4", 2'b00, 1'b0, 2'b00, 3'd1);
        tick(); chk_out("ct_e5", 2'b10, 1'b1, 2'b00, 3'd0);
        tick(); chk_out("ct_e6", 2'b10, 1'b1, 2'b00, 3'd1);
        tick(); chk_out("ct_e7", 2'b10, 1'b1, 2'b00, 3'd2);
        tick(); chk_out("ct_e8", 2'b00, 1'b0, 2'b10, 3'd2);
        req = 2'b00;
        tick(); chk_out("ct_e9", 2'b00, 1'b0, 2'b00, 3'd2);

        // alternation with both held high, zero-length jobs
        req  = 2'b11;
        len0 = 3'd0;
        len1 = 3'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("alt.gnt",   32'(gnt),   (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("alt.count", 32'(count), 32'h0);
            tick();
            chk("alt.done",  32'(done),  (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("alt.gnt0",  32'(gnt),   32'h0);
            tick();
            chk("alt.dead",  32'(done),  32'h0);
            chk("alt.idle",  32'(gnt),   32'h0);
        end
        req = 2'b00;

        // abort: requester 0 drops at count=2, pending requester 1 follows
        req  = 2'b11;
        len0 = 3'd5;
        len1 = 3'd3;
        tick(); chk_out("ab_g",  2'b01, 1'b1, 2'b00, 3'd0);
        tick(); chk_out("ab_c1", 2'b01, 1'b1, 2'b00, 3'd1);
        tick(); chk_out("ab_c2", 2'b01, 1'b1, 2'b00, 3'd2);
        req = 2'b10;
        tick(); chk_out("ab_drop", 2'b00, 1'b0, 2'b00, 3'd2);
        tick(); chk_out("ab_g1",   2'b10, 1'b1, 2'b00, 3'd0);
        req = 2'b00;
        tick(); chk_out("ab_drop1", 2'b00, 1'b0, 2'b00, 3'd0);

        // maximum length: count reaches 7 without wrap, len change ignored
        req  = 2'b01;
        len0 = 3'd7;
        tick(); chk_out("mx_g", 2'b01, 1'b1, 2'b00, 3'd0);
        len0 = 3'd2;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("mx.count", 32'(count), 32'(i));
            chk("mx.gnt",   32'(gnt),   32'h1);
        end
        tick(); chk_out("mx_done", 2'b00, 1'b0, 2'b01, 3'd7);
        req = 2'b00;
        tick(); chk_out("mx_idle", 2'b00, 1'b0, 2'b00, 3'd7);

        // reset mid-run at count=4
        req  = 2'b01;
        len0 = 3'd6;
        tick(); chk_out("rm_g", 2'b01, 1'b1, 2'b00, 3'd0);
        tick(); tick(); tick(); tick();
        chk("rm.count4", 32'(count), 32'h4);
        reset = 1'b1;
        req   = 2'b11;
        tick(); chk_out("rm_rst", 2'b00, 1'b0, 2'b00, 3'd0);
        reset = 1'b0;
        tick(); chk_out("rm_rel", 2'b01, 1'b1, 2'b00, 3'd0);
        reset = 1'b1;
        req   = 2'b00;
        tick(); chk_out("rm_rst2", 2'b00, 1'b0, 2'b00, 3'd0);
        reset = 1'b0;

        // single job, len0=3
        req  = 2'b01;
        len0 = 3'd3;
        tick(); chk_out("sj_g",  2'b01, 1'b1, 2'b00, 3'd0);
        tick(); chk_out("sj_c1", 2'b01, 1'b1, 2'b00, 3'd1);
        tick(); chk_out("sj_c2", 2'b01, 1'b1, 2'b00, 3'd2);
        tick(); chk_out("sj_c3", 2'b01, 1'b1, 2'b00, 3'd3);
        tick(); chk_out("sj_done", 2'b00, 1'b0, 2'b01, 3'd3);
        req = 2'b00;
        tick(); chk_out("sj_dead", 2'b00, 1'b0, 2'b00, 3'd3);
        tick(); chk_out("sj_idle", 2'b00, 1'b0, 2'b00, 3'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
